// File: rtl/param_register_file_if.sv
// Register-file port bundle: two read ports, one write port, the clear request and
// the status outputs.
//   RA, RB      read addresses            BusA, BusB  read data
//   RW, BusW    write address / data      RegWr       write enable
//   Clr         clear request             Busy        clear sweep in progress
//   WrDrop      one-cycle pulse after a write was discarded
// The master modport is the pipeline side and the slave modport is the register file.
interface param_register_file_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 5
);
    logic [AW-1:0]    RA;
    logic [AW-1:0]    RB;
    logic [AW-1:0]    RW;
    logic [WIDTH-1:0] BusA;
    logic [WIDTH-1:0] BusB;
    logic [WIDTH-1:0] BusW;
    logic             RegWr;
    logic             Clr;
    logic             Busy;
    logic             WrDrop;

    modport master (
        output RA, RB, RW, BusW, RegWr, Clr,
        input  BusA, BusB, Busy, WrDrop
    );

    modport slave (
        input  RA, RB, RW, BusW, RegWr, Clr,
        output BusA, BusB, Busy, WrDrop
    );
endinterface

// File: rtl/param_register_file.sv
// Parametrised single-write, dual-read register file with a hardware clear sweep.
// The array has no reset, so it can map onto RAM/LUT-RAM. After reset, or after a Clr
// request, a sequencer writes zero to one entry per cycle, and Busy stays high for
// DEPTH cycles. During the sweep, reads return 0 and writes are dropped. Each dropped
// write raises WrDrop for one cycle.
// Ports:
//   Clk     clock; all state changes on the rising edge
//   Resetn  asynchronous active-low reset; starts a fresh sweep from entry 0
//   bus     param_register_file_if.slave: RA/RB/BusA/BusB reads, RW/BusW/RegWr write,
//           Clr request, Busy and WrDrop status
// Optional feature: define REGFILE_BYPASS_EN to forward BusW to a read port in the same
// cycle when that port's read address matches RW.
module param_register_file #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                  Clk,
    input  logic                  Resetn,
    param_register_file_if.slave  bus
);
    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e           state_q;
    logic [AW-1:0]    clr_idx_q;
    logic             wr_drop_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic busy;
    logic w_zero;
    logic wr_en;

    assign busy   = (state_q == StClear);
    // A write to the hardwired zero entry is ignored and does not count as a drop.
    assign w_zero = (ZERO_REG != 0) && (bus.RW == '0);
    // If Clr and a write arrive on the same edge, the clear takes priority.
    assign wr_en  = bus.RegWr && !busy && !bus.Clr && !w_zero;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= bus.RegWr && (busy || bus.Clr);
            case (state_q)
                StClear: begin
                    // Clr during the sweep is ignored. The index wraps to 0 on the last entry.
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == LastIdx) begin
                        state_q <= StIdle;
                    end
                end
                StIdle: begin
                    if (bus.Clr) begin
                        state_q   <= StClear;
                        clr_idx_q <= '0;
                    end
                end
                default: begin
                    state_q   <= StClear;
                    clr_idx_q <= '0;
                end
            endcase
        end
    end

    // Storage is left without reset so it can map onto RAM. The sweep does the zeroing.
    always_ff @(posedge Clk) begin
        if (busy) begin
            mem_q[clr_idx_q] <= '0;
        end else if (wr_en) begin
            mem_q[bus.RW] <= bus.BusW;
        end
    end

    always_comb begin
        bus.BusA = mem_q[bus.RA];
        bus.BusB = mem_q[bus.RB];
`ifdef REGFILE_BYPASS_EN
        if (bus.RegWr && !w_zero) begin
            if (bus.RA == bus.RW) bus.BusA = bus.BusW;
            if (bus.RB == bus.RW) bus.BusB = bus.BusW;
        end
`endif
        // Busy and the zero entry override both stored and forwarded data.
        if (busy || ((ZERO_REG != 0) && (bus.RA == '0))) bus.BusA = '0;
        if (busy || ((ZERO_REG != 0) && (bus.RB == '0))) bus.BusB = '0;
    end

    assign bus.Busy   = busy;
    assign bus.WrDrop = wr_drop_q;
endmodule

// File: tb/tb_param_register_file.sv
module tb_param_register_file;
    logic Clk = 1'b0;
    logic Resetn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    param_register_file_if #(.WIDTH(32), .AW(5)) ifz ();
    param_register_file_if #(.WIDTH(32), .AW(5)) ifn ();

    param_register_file #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(1)) dut_z (
        .Clk(Clk), .Resetn(Resetn), .bus(ifz.slave)
    );
    param_register_file #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(0)) dut_n (
        .Clk(Clk), .Resetn(Resetn), .bus(ifn.slave)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                         input logic [31:0] busw, input logic regwr, input logic clr);
        ifz.RA = ra; ifz.RB = rb; ifz.RW = rw; ifz.BusW = busw; ifz.RegWr = regwr; ifz.Clr = clr;
        ifn.RA = ra; ifn.RB = rb; ifn.RW = rw; ifn.BusW = busw; ifn.RegWr = regwr; ifn.Clr = clr;
    endtask

    task automatic test_reset();
        drive(5'd5, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        Resetn = 1'b0;
        #12;
        checks++;
        if (ifz.Busy !== 1'b1 || ifz.WrDrop !== 1'b0 || ifz.BusA !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: Busy=%b WrDrop=%b BusA=%h, required 1 0 0",
                     ifz.Busy, ifz.WrDrop, ifz.BusA);
        end
        tick();
        Resetn = 1'b1;
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (ifz.Busy !== 1'b1 || ifz.BusA !== 32'h0) begin
                errors++;
                $display("FAIL reset_sweep cycle %0d: Busy=%b BusA=%h, required 1 0",
                         k, ifz.Busy, ifz.BusA);
            end
            tick();
        end
        checks++;
        if (ifz.Busy !== 1'b0 || ifz.BusA !== 32'h0 || ifn.Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_sweep_end: Busy=%b BusA=%h, required 0 0", ifz.Busy, ifz.BusA);
        end
    endtask

    task automatic test_write_read();
        drive(5'd0, 5'd0, 5'd7, 32'hDEADBEEF, 1'b1, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd31, 32'h12345678, 1'b1, 1'b0);
        tick();
        checks++;
        if (ifz.WrDrop !== 1'b0) begin
            errors++;
            $display("FAIL write_no_drop: WrDrop=%b, required 0", ifz.WrDrop);
        end
        drive(5'd7, 5'd31, 5'd0, 32'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (ifz.BusA !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_r7: BusA=%h, required deadbeef", ifz.BusA);
        end
        checks++;
        if (ifz.BusB !== 32'h12345678) begin
            errors++;
            $display("FAIL read_r31: BusB=%h, required 12345678", ifz.BusB);
        end
        drive(5'd31, 5'd31, 5'd0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ifz.BusA !== 32'h12345678 || ifz.BusB !== 32'h12345678) begin
            errors++;
            $display("FAIL read_same_addr: BusA=%h BusB=%h, required 12345678 both",
                     ifz.BusA, ifz.BusB);
        end
    endtask

    task automatic test_zero_reg();
        drive(5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ifz.BusA !== 32'h0 || ifz.BusB !== 32'h0) begin
            errors++;
            $display("FAIL zero_reg_read: BusA=%h BusB=%h, required 0", ifz.BusA, ifz.BusB);
        end
        checks++;
        if (ifz.WrDrop !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg_no_drop: WrDrop=%b, required 0", ifz.WrDrop);
        end
        checks++;
        if (ifn.BusA !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL plain_r0_read: BusA=%h, required ffffffff", ifn.BusA);
        end
    endtask

    task automatic test_clear_collision();
        drive(5'd0, 5'd0, 5'd3, 32'h000000AA, 1'b1, 1'b0);
        tick();
        drive(5'd3, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ifz.BusA !== 32'h000000AA) begin
            errors++;
            $display("FAIL r3_pre_clear: BusA=%h, required 000000aa", ifz.BusA);
        end
        drive(5'd3, 5'd0, 5'd3, 32'h00000055, 1'b1, 1'b1);
        tick();
        drive(5'd3, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (ifz.WrDrop !== 1'b1) begin
            errors++;
            $display("FAIL collision_drop: WrDrop=%b, required 1", ifz.WrDrop);
        end
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (ifz.Busy !== 1'b1 || ifz.BusA !== 32'h0) begin
                errors++;
                $display("FAIL clear_sweep cycle %0d: Busy=%b BusA=%h, required 1 0",
                         k, ifz.Busy, ifz.BusA);
            end
            if (k == 5) drive(5'd3, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
            if (k == 10) drive(5'd3, 5'd0, 5'd4, 32'h00000077, 1'b1, 1'b0);
            tick();
            if (k == 1) begin
                checks++;
                if (ifz.WrDrop !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_one_cycle: WrDrop=%b, required 0", ifz.WrDrop);
                end
            end
            if (k == 10) begin
                checks++;
                if (ifz.WrDrop !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_write_drop: WrDrop=%b, required 1", ifz.WrDrop);
                end
            end
            drive(5'd3, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        end
        #1;
        checks++;
        if (ifz.Busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_sweep_end: Busy=%b, required 0", ifz.Busy);
        end
        checks++;
        if (ifz.BusA !== 32'h0) begin
            errors++;
            $display("FAIL r3_post_clear: BusA=%h, required 0", ifz.BusA);
        end
        drive(5'd4, 5'd7, 5'd0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ifz.BusA !== 32'h0 || ifz.BusB !== 32'h0) begin
            errors++;
            $display("FAIL r4_r7_post_clear: BusA=%h BusB=%h, required 0 0", ifz.BusA, ifz.BusB);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
        drive(5'd0, 5'd0, 5'd9, 32'h00001111, 1'b1, 1'b0);
        tick();
        drive(5'd9, 5'd9, 5'd9, 32'hCAFE0001, 1'b1, 1'b0);
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hCAFE0001;
`else
        exp_same = 32'h00001111;
`endif
        checks++;
        if (ifz.BusA !== exp_same || ifz.BusB !== exp_same) begin
            errors++;
            $display("FAIL bypass_same_cycle: BusA=%h BusB=%h, required %h", ifz.BusA, ifz.BusB,
                     exp_same);
        end
        tick();
        drive(5'd9, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ifz.BusA !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL write_next_cycle: BusA=%h, required cafe0001", ifz.BusA);
        end
        drive(5'd0, 5'd0, 5'd0, 32'h0BADF00D, 1'b1, 1'b0);
        #1;
        checks++;
        if (ifz.BusA !== 32'h0) begin
            errors++;
            $display("FAIL zero_reg_no_bypass: BusA=%h, required 0", ifz.BusA);
        end
        drive(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        drive(5'd9, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(5'd9, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) tick();
        Resetn = 1'b0;
        #2;
        checks++;
        if (ifz.Busy !== 1'b1 || ifz.WrDrop !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: Busy=%b WrDrop=%b, required 1 0",
                     ifz.Busy, ifz.WrDrop);
        end
        Resetn = 1'b1;
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (ifz.Busy !== 1'b1) begin
                errors++;
                $display("FAIL mid_reset_sweep cycle %0d: Busy=%b, required 1", k, ifz.Busy);
            end
            tick();
        end
        checks++;
        if (ifz.Busy !== 1'b0 || ifz.BusA !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_end: Busy=%b BusA=%h, required 0 0", ifz.Busy, ifz.BusA);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_clear_collision();
        test_bypass();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
